// File: rtl/threshold_vote_window.sv
// Per-sample threshold vote (popcount >= THRESH) with windowed hit counting
// and a strict-majority verdict over every WINDOW valid samples.
module threshold_vote_window #(
  parameter int N      = 4,
  parameter int THRESH = 3,
  parameter int WINDOW = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [N-1:0]                     votes,
  output logic                             f,
  output logic                             f_valid,
  output logic                             win_done,
  output logic [$clog2(WINDOW+1)-1:0]      win_count,
  output logic                             win_maj
);

  localparam int PW = $clog2(N + 1);
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW:0] WIN_LIMIT = (CW + 1)'(WINDOW);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] hits;

  logic [PW-1:0] pop;
  logic          vote;
  logic [CW-1:0] base_cnt;
  logic [CW-1:0] base_hits;
  logic [CW-1:0] hits_total;
  logic          last_sample;

  always_comb begin
    // NOTE: assign a default before the loop so the accumulator never
    // depends on its previous value, which would otherwise infer a latch.
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(votes[i]);
    end
  end

  assign vote = (pop >= PW'(THRESH));

  // Outside ACCUM the current sample opens a fresh window, so it counts from zero.
  always_comb begin
    base_cnt    = (state == ACCUM) ? sample_cnt : '0;
    base_hits   = (state == ACCUM) ? hits : '0;
    hits_total  = base_hits + CW'(vote);
    last_sample = (base_cnt == CW'(WINDOW - 1));
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      hits       <= '0;
      f          <= 1'b0;
      f_valid    <= 1'b0;
      win_done   <= 1'b0;
      win_count  <= '0;
      win_maj    <= 1'b0;
    end else begin
      f_valid  <= in_valid;
      win_done <= 1'b0;
      if (in_valid) begin
        f <= vote;
      end

      if (clear) begin
        state      <= IDLE;
        sample_cnt <= '0;
        hits       <= '0;
      end else if (in_valid) begin
        if (last_sample) begin
          state      <= DONE;
          sample_cnt <= '0;
          hits       <= '0;
          win_done   <= 1'b1;
          win_count  <= hits_total;
          win_maj    <= ({hits_total, 1'b0} > WIN_LIMIT);
        end else begin
          state      <= ACCUM;
          sample_cnt <= base_cnt + CW'(1);
          hits       <= hits_total;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_threshold_vote_window.sv
// Randomized bench for threshold_vote_window against a queue-based window model.
module tb_threshold_vote_window;

  localparam int N      = 4;
  localparam int THRESH = 3;
  localparam int WINDOW = 8;
  localparam int CW     = $clog2(WINDOW + 1);

  logic          clock;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [N-1:0]  votes;
  logic          f;
  logic          f_valid;
  logic          win_done;
  logic [CW-1:0] win_count;
  logic          win_maj;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model state: expected outputs and the hit flags of the open window.
  bit exp_f, exp_fv, exp_done, exp_maj;
  int exp_count;
  int win_q[$];

  threshold_vote_window #(.N(N), .THRESH(THRESH), .WINDOW(WINDOW)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .votes     (votes),
    .f         (f),
    .f_valid   (f_valid),
    .win_done  (win_done),
    .win_count (win_count),
    .win_maj   (win_maj)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    exp_f = 0; exp_fv = 0; exp_done = 0; exp_count = 0; exp_maj = 0;
    win_q.delete();
  endtask

  // Drive one cycle, advance the model on the edge, return 1 time unit later.
  task automatic step(input bit c, input bit v, input logic [N-1:0] d);
    int sum;
    clear = c; in_valid = v; votes = d;
    @(posedge clock);
    exp_fv   = v;
    exp_done = 0;
    if (v) exp_f = ($countones(d) >= THRESH);
    if (c) begin
      win_q.delete();
    end else if (v) begin
      win_q.push_back(($countones(d) >= THRESH) ? 1 : 0);
      if (win_q.size() == WINDOW) begin
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        exp_count = sum;
        exp_maj   = (2 * sum > WINDOW);
        exp_done  = 1;
        win_q.delete();
      end
    end
    #1;
  endtask

  function automatic logic [N-1:0] rand_votes(input bit hit);
    logic [N-1:0] v;
    do v = N'($urandom()); while (($countones(v) >= THRESH) != hit);
    return v;
  endfunction

  // Random placement of exactly k hit samples among WINDOW slots.
  function automatic void gen_hits(input int k, output bit h[WINDOW]);
    bit t;
    int j;
    for (int i = 0; i < WINDOW; i++) h[i] = (i < k);
    for (int i = WINDOW - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = h[i]; h[i] = h[j]; h[j] = t;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; votes = '0;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++; if (f !== 1'b0) $display("FAIL reset_f: got %0b expected 0", f); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL reset_f_valid: got %0b expected 0", f_valid); else pass_cnt++;
    total_cnt++; if (win_done !== 1'b0) $display("FAIL reset_win_done: got %0b expected 0", win_done); else pass_cnt++;
    total_cnt++; if (win_count !== '0) $display("FAIL reset_win_count: got %0d expected 0", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b0) $display("FAIL reset_win_maj: got %0b expected 0", win_maj); else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_all_patterns();
    step(1, 0, '0);
    for (int p = 0; p < 16; p++) begin
      step(0, 1, N'(p));
      total_cnt++; if (f !== exp_f) $display("FAIL pattern_f[%0d]: got %0b expected %0b", p, f, exp_f); else pass_cnt++;
      total_cnt++; if (f_valid !== 1'b1) $display("FAIL pattern_f_valid[%0d]: got %0b expected 1", p, f_valid); else pass_cnt++;
    end
  endtask

  task automatic test_window_majority();
    bit h[WINDOW];
    step(1, 0, '0);
    gen_hits(5, h);
    for (int i = 0; i < WINDOW; i++) begin
      step(0, 1, rand_votes(h[i]));
      total_cnt++; if (win_done !== (i == WINDOW - 1)) $display("FAIL maj_win_done[%0d]: got %0b expected %0b", i, win_done, i == WINDOW - 1); else pass_cnt++;
    end
    total_cnt++; if (win_count !== CW'(5)) $display("FAIL maj_win_count: got %0d expected 5", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b1) $display("FAIL maj_win_maj: got %0b expected 1", win_maj); else pass_cnt++;
    step(0, 0, '0);
    total_cnt++; if (win_done !== 1'b0) $display("FAIL maj_done_pulse: got %0b expected 0", win_done); else pass_cnt++;
  endtask

  task automatic test_tie();
    bit h[WINDOW];
    step(1, 0, '0);
    gen_hits(4, h);
    for (int i = 0; i < WINDOW; i++) step(0, 1, rand_votes(h[i]));
    total_cnt++; if (win_done !== 1'b1) $display("FAIL tie_win_done: got %0b expected 1", win_done); else pass_cnt++;
    total_cnt++; if (win_count !== CW'(4)) $display("FAIL tie_win_count: got %0d expected 4", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b0) $display("FAIL tie_win_maj: got %0b expected 0", win_maj); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, N'($urandom()));
      total_cnt++; if (win_done !== 1'b0) $display("FAIL hold_win_done[%0d]: got %0b expected 0", i, win_done); else pass_cnt++;
      total_cnt++; if (win_count !== CW'(4)) $display("FAIL hold_win_count[%0d]: got %0d expected 4", i, win_count); else pass_cnt++;
      total_cnt++; if (win_maj !== 1'b0) $display("FAIL hold_win_maj[%0d]: got %0b expected 0", i, win_maj); else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    bit h[WINDOW];
    int k;
    step(1, 0, '0);
    k = $urandom_range(0, WINDOW);
    gen_hits(k, h);
    for (int i = 0; i < WINDOW; i++) begin
      repeat ($urandom_range(0, 3)) begin
        step(0, 0, N'($urandom()));
        total_cnt++; if (f !== exp_f) $display("FAIL gap_f: got %0b expected %0b", f, exp_f); else pass_cnt++;
        total_cnt++; if (f_valid !== 1'b0) $display("FAIL gap_f_valid: got %0b expected 0", f_valid); else pass_cnt++;
        total_cnt++; if (win_done !== 1'b0) $display("FAIL gap_win_done: got %0b expected 0", win_done); else pass_cnt++;
      end
      step(0, 1, rand_votes(h[i]));
      total_cnt++; if (f !== exp_f) $display("FAIL gap_sample_f[%0d]: got %0b expected %0b", i, f, exp_f); else pass_cnt++;
      total_cnt++; if (win_done !== exp_done) $display("FAIL gap_sample_done[%0d]: got %0b expected %0b", i, win_done, exp_done); else pass_cnt++;
    end
    total_cnt++; if (win_count !== CW'(k)) $display("FAIL gap_win_count: got %0d expected %0d", win_count, k); else pass_cnt++;
    total_cnt++; if (win_maj !== exp_maj) $display("FAIL gap_win_maj: got %0b expected %0b", win_maj, exp_maj); else pass_cnt++;
  endtask

  task automatic test_clear();
    bit h[WINDOW];
    int prev_count;
    bit prev_maj;
    step(1, 0, '0);
    prev_count = exp_count;
    prev_maj   = exp_maj;
    for (int i = 0; i < 3; i++) step(0, 1, rand_votes(1));
    step(1, 1, '1);
    total_cnt++; if (f !== 1'b1) $display("FAIL clear_f: got %0b expected 1", f); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b1) $display("FAIL clear_f_valid: got %0b expected 1", f_valid); else pass_cnt++;
    total_cnt++; if (win_done !== 1'b0) $display("FAIL clear_win_done: got %0b expected 0", win_done); else pass_cnt++;
    total_cnt++; if (win_count !== CW'(prev_count)) $display("FAIL clear_keep_count: got %0d expected %0d", win_count, prev_count); else pass_cnt++;
    total_cnt++; if (win_maj !== prev_maj) $display("FAIL clear_keep_maj: got %0b expected %0b", win_maj, prev_maj); else pass_cnt++;
    gen_hits(2, h);
    for (int i = 0; i < WINDOW; i++) begin
      step(0, 1, rand_votes(h[i]));
      total_cnt++; if (win_done !== (i == WINDOW - 1)) $display("FAIL fresh_win_done[%0d]: got %0b expected %0b", i, win_done, i == WINDOW - 1); else pass_cnt++;
    end
    total_cnt++; if (win_count !== CW'(2)) $display("FAIL fresh_win_count: got %0d expected 2", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b0) $display("FAIL fresh_win_maj: got %0b expected 0", win_maj); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit h[WINDOW];
    bit t;
    int k2, k3;
    step(1, 0, '0);
    gen_hits(6, h);
    for (int i = 0; i < WINDOW; i++) step(0, 1, rand_votes(h[i]));
    total_cnt++; if (win_done !== 1'b1) $display("FAIL b2b_w1_done: got %0b expected 1", win_done); else pass_cnt++;
    total_cnt++; if (win_count !== CW'(6)) $display("FAIL b2b_w1_count: got %0d expected 6", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b1) $display("FAIL b2b_w1_maj: got %0b expected 1", win_maj); else pass_cnt++;
    // Window 2 opens with a hit that lands in the DONE cycle.
    k2 = $urandom_range(1, WINDOW);
    gen_hits(k2, h);
    for (int j = 1; j < WINDOW; j++) begin
      if (!h[0] && h[j]) begin t = h[0]; h[0] = h[j]; h[j] = t; end
    end
    for (int i = 0; i < WINDOW; i++) begin
      step(0, 1, rand_votes(h[i]));
      total_cnt++; if (win_done !== (i == WINDOW - 1)) $display("FAIL b2b_w2_done[%0d]: got %0b expected %0b", i, win_done, i == WINDOW - 1); else pass_cnt++;
    end
    total_cnt++; if (win_count !== CW'(k2)) $display("FAIL b2b_w2_count: got %0d expected %0d", win_count, k2); else pass_cnt++;
    total_cnt++; if (win_maj !== (2 * k2 > WINDOW)) $display("FAIL b2b_w2_maj: got %0b expected %0b", win_maj, 2 * k2 > WINDOW); else pass_cnt++;
    for (int i = 0; i < 3; i++) step(0, 1, rand_votes(1));
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    total_cnt++; if (f !== 1'b0) $display("FAIL areset_f: got %0b expected 0", f); else pass_cnt++;
    total_cnt++; if (f_valid !== 1'b0) $display("FAIL areset_f_valid: got %0b expected 0", f_valid); else pass_cnt++;
    total_cnt++; if (win_count !== '0) $display("FAIL areset_win_count: got %0d expected 0", win_count); else pass_cnt++;
    total_cnt++; if (win_maj !== 1'b0) $display("FAIL areset_win_maj: got %0b expected 0", win_maj); else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    k3 = $urandom_range(0, WINDOW);
    gen_hits(k3, h);
    for (int i = 0; i < WINDOW; i++) begin
      step(0, 1, rand_votes(h[i]));
      total_cnt++; if (win_done !== (i == WINDOW - 1)) $display("FAIL post_reset_done[%0d]: got %0b expected %0b", i, win_done, i == WINDOW - 1); else pass_cnt++;
    end
    total_cnt++; if (win_count !== CW'(k3)) $display("FAIL post_reset_count: got %0d expected %0d", win_count, k3); else pass_cnt++;
    total_cnt++; if (win_maj !== exp_maj) $display("FAIL post_reset_maj: got %0b expected %0b", win_maj, exp_maj); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_patterns();
    test_window_majority();
    test_tie();
    test_gaps();
    test_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
